// File: rtl/hilo_div_unit.sv
// ============================================================================
// Module  : hilo_div_unit
// Purpose : Architectural HI/LO pair with MTHI/MTLO writes and an iterative
//           radix-2 restoring DIV/DIVU that stalls the pipeline while busy.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_div_unit #(
    parameter int WIDTH     = 32,
    parameter int DIV0_FAST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       hilo_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_MTHI = 3'b001;
    localparam logic [2:0] OP_MTLO = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;

    logic             is_div;
    logic             is_divide;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    assign is_div    = (hilo_op == OP_DIV);
    assign is_divide = (hilo_op == OP_DIV) || (hilo_op == OP_DIVU);
    assign abs_a     = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b     = src_b[WIDTH-1] ? -src_b : src_b;

    // One restoring step: bring in the next dividend bit, keep the difference on no borrow.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quot[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        rem_nxt  = shifted;
        quot_nxt = {quot[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt  = trial;
            quot_nxt = {quot[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        stall_req = 1'b0;
        case (state)
            IDLE:    stall_req = valid && !flush && is_divide;
            CALC:    stall_req = !flush;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        case (hilo_op)
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            OP_DIV, OP_DIVU: begin
                                rem     <= '0;
                                quot    <= is_div ? abs_a : src_a;
                                divisor <= is_div ? abs_b : src_b;
                                neg_q   <= is_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_r   <= is_div && src_a[WIDTH-1];
                                if ((DIV0_FAST != 0) && (src_b == '0)) begin
                                    lo    <= '1;
                                    hi    <= src_a;
                                    state <= DONE;
                                end else begin
                                    state <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi    <= neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
                        lo    <= neg_q ? -quot_nxt : quot_nxt;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hi_out = hi;
    assign lo_out = lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
// ============================================================================
// Module  : tb_hilo_div_unit
// Purpose : Directed self-checking bench for hilo_div_unit (WIDTH=32, DIV0_FAST=1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_div_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [2:0]  hilo_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_div_unit #(.WIDTH(32), .DIV0_FAST(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .hilo_op   (hilo_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a divide, count stalled cycles, check HI/LO in the DONE cycle.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_stall);
        int n;
        n       = 0;
        valid   = 1'b1;
        hilo_op = op;
        src_a   = a;
        src_b   = b;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall_req) break;
            n++;
            step();
        end
        check_val({tag, " stall"}, 32'(n), 32'(exp_stall));
        check_val({tag, " lo"}, lo_out, exp_lo);
        check_val({tag, " hi"}, hi_out, exp_hi);
        step();
        valid   = 1'b0;
        hilo_op = 3'b000;
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; hilo_op = 3'b000; src_a = '0; src_b = '0; flush = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_val("reset hi", hi_out, 32'h0);
        check_val("reset lo", lo_out, 32'h0);
        check_val("reset stall", 32'(stall_req), 32'h0);

        // MTHI / MTLO, visible only after the edge
        valid = 1'b1; hilo_op = 3'b001; src_a = 32'h12345678;
        #1;
        check_val("mthi no bypass", hi_out, 32'h0);
        check_val("mthi stall", 32'(stall_req), 32'h0);
        step();
        check_val("mthi hi", hi_out, 32'h12345678);
        hilo_op = 3'b010; src_a = 32'h9ABCDEF0;
        step();
        check_val("mtlo lo", lo_out, 32'h9ABCDEF0);
        check_val("mtlo hi kept", hi_out, 32'h12345678);
        hilo_op = 3'b001; src_a = 32'hDEADBEEF; flush = 1'b1;
        step();
        flush = 1'b0; valid = 1'b0; hilo_op = 3'b000;
        check_val("mthi flushed", hi_out, 32'h12345678);
        hilo_op = 3'b110; valid = 1'b1; src_a = 32'h0BADF00D;
        step();
        valid = 1'b0; hilo_op = 3'b000;
        check_val("rsvd op hi", hi_out, 32'h12345678);
        check_val("rsvd op lo", lo_out, 32'h9ABCDEF0);

        run_div("div 7/2", 3'b011, 32'd7, 32'd2, 32'd3, 32'd1, 33);
        run_div("div -7/2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("div min/-1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33);
        run_div("div 7/-2", 3'b011, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        run_div("divu big", 3'b100, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33);
        run_div("divu b2b", 3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div0", 3'b011, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1);

        // flush in CALC cycle 10
        valid = 1'b1; hilo_op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
        step();
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        check_val("flush stall low", 32'(stall_req), 32'h0);
        step();
        flush = 1'b0; valid = 1'b0; hilo_op = 3'b000;
        #1;
        check_val("post flush stall", 32'(stall_req), 32'h0);
        for (int i = 0; i < 40; i++) step();
        check_val("flush hi kept", hi_out, 32'd5);
        check_val("flush lo kept", lo_out, 32'hFFFFFFFF);

        // reset mid-CALC
        valid = 1'b1; hilo_op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
        step();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1; valid = 1'b0; hilo_op = 3'b000;
        #1;
        check_val("rst mid hi", hi_out, 32'h0);
        check_val("rst mid lo", lo_out, 32'h0);
        check_val("rst mid stall", 32'(stall_req), 32'h0);
        for (int i = 0; i < 40; i++) step();
        check_val("rst mid lo later", lo_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
